// File: rtl/bist_scheduler_pkg.sv
// Shared types and default widths for the BIST scheduler.
package bist_scheduler_pkg;

  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_SIG_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_RUN,
    RUN,
    CHECK,
    RELEASE
  } state_t;

endpackage

// File: rtl/bist_scheduler_rr_arbiter.sv
// Round-robin selector: combinational pick starting after the registered
// pointer; the pointer moves to the winner when update is asserted.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic [IW-1:0] ptr;

  // Search from the core after the last winner, wrapping around.
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!any && req[IW'((32'(ptr) + i) % N_REQ)]) begin
        any     = 1'b1;
        gnt_idx = IW'((32'(ptr) + i) % N_REQ);
      end
    end
    gnt = any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  // Pointer starts at the last core so the first search begins at core 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= IW'(N_REQ - 1);
    else if (update && any)
      ptr <= gnt_idx;
  end

endmodule

// File: rtl/bist_scheduler.sv
// Schedules BIST sessions of several cores onto one shared engine,
// checks the resulting MISR signature and keeps per-core verdicts.
module bist_scheduler
  import bist_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned SIG_W = DEF_SIG_W,
  parameter int unsigned TMO   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [CNT_W-1:0]       pat_count,
  input  logic [N_REQ*SIG_W-1:0] exp_sig,
  output logic                   eng_start,
  output logic [CNT_W-1:0]       eng_nclock,
  input  logic                   eng_init,
  input  logic                   eng_running,
  input  logic                   eng_finish,
  input  logic [SIG_W-1:0]       misr_sig,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       pass,
  output logic [N_REQ-1:0]       fail,
  output logic                   tmo_err
);

  localparam int unsigned IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W = (TMO > 0) ? $clog2(TMO + 1) : 1;

  state_t           state, state_nx;
  logic             arb_load, sig_load, chk_en, tmo_hit;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx, gidx;
  logic             arb_any;
  logic [WD_W-1:0]  wdog;
  logic             wd_expire;
  logic [SIG_W-1:0] sig_q;
  logic             sig_match;

  // The engine init phase needs no action from the scheduler.
  logic unused_init;
  assign unused_init = eng_init;

  assign wd_expire = (32'(wdog) + 32'd1) >= TMO;
  assign sig_match = (sig_q == exp_sig[32'(gidx)*SIG_W +: SIG_W]);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .update  (arb_load),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_nx  = state;
    arb_load  = 1'b0;
    sig_load  = 1'b0;
    chk_en    = 1'b0;
    tmo_hit   = 1'b0;
    eng_start = (state == LAUNCH);
    busy      = (state != IDLE);
    case (state)
      IDLE:     if (|req) state_nx = ARB;
      ARB: begin
        if (arb_any) begin
          arb_load = 1'b1;
          state_nx = LAUNCH;
        end else begin
          state_nx = IDLE;
        end
      end
      LAUNCH:   state_nx = WAIT_RUN;
      WAIT_RUN: begin
        if (eng_running && eng_finish) begin
          sig_load = 1'b1;
          state_nx = CHECK;
        end else if (wd_expire) begin
          tmo_hit  = 1'b1;
          state_nx = RELEASE;
        end else if (eng_running) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (eng_finish) begin
          sig_load = 1'b1;
          state_nx = CHECK;
        end else if (wd_expire) begin
          tmo_hit  = 1'b1;
          state_nx = RELEASE;
        end
      end
      CHECK: begin
        chk_en   = 1'b1;
        state_nx = RELEASE;
      end
      RELEASE:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Session datapath: grant/count latch, watchdog, signature and verdicts.
  // The signature is captured with eng_finish so CHECK does not depend on
  // the engine holding misr_sig for an extra cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      gidx       <= '0;
      eng_nclock <= '0;
      wdog       <= '0;
      sig_q      <= '0;
      done       <= '0;
      pass       <= '0;
      fail       <= '0;
      tmo_err    <= 1'b0;
    end else begin
      done <= '0;
      if (arb_load) begin
        grant      <= arb_gnt;
        gidx       <= arb_idx;
        eng_nclock <= (pat_count == '0) ? CNT_W'(1) : pat_count;
      end
      if (state == LAUNCH)
        wdog <= '0;
      else if ((state == WAIT_RUN || state == RUN) && !wd_expire)
        wdog <= wdog + WD_W'(1);
      if (sig_load)
        sig_q <= misr_sig;
      if (chk_en) begin
        grant      <= '0;
        done[gidx] <= 1'b1;
        pass[gidx] <= sig_match;
        fail[gidx] <= !sig_match;
      end
      if (tmo_hit) begin
        grant      <= '0;
        done[gidx] <= 1'b1;
        pass[gidx] <= 1'b0;
        fail[gidx] <= 1'b1;
        tmo_err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bist_scheduler.sv
// Self-checking bench for bist_scheduler: engine model, session-level
// reference model with per-cycle compare, plus directed literal checks.
module tb_bist_scheduler;

  localparam int N     = 4;
  localparam int CW    = 8;
  localparam int SW    = 16;
  localparam int TMO_T = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [CW-1:0]   pat_count;
  logic [N*SW-1:0] exp_sig;
  logic            eng_start;
  logic [CW-1:0]   eng_nclock;
  logic            eng_init, eng_running, eng_finish;
  logic [SW-1:0]   misr_sig;
  logic [N-1:0]    grant, done, pass, fail;
  logic            busy, tmo_err;

  always #5 clk = ~clk;

  bist_scheduler #(.N_REQ(N), .CNT_W(CW), .SIG_W(SW), .TMO(TMO_T)) dut (
    .clk(clk), .reset(reset), .req(req), .pat_count(pat_count),
    .exp_sig(exp_sig), .eng_start(eng_start), .eng_nclock(eng_nclock),
    .eng_init(eng_init), .eng_running(eng_running), .eng_finish(eng_finish),
    .misr_sig(misr_sig), .grant(grant), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .tmo_err(tmo_err)
  );

  int tests = 0;
  int fails = 0;

  logic [SW-1:0] exp_arr [N] = '{16'h1234, 16'hBEE0, 16'h5A5A, 16'hC3C3};
  assign exp_sig = {exp_arr[3], exp_arr[2], exp_arr[1], exp_arr[0]};

  // Engine behaviour: 0 normal, 1 never runs, 2 running+finish together
  int            eng_mode;
  int            run_len;
  int            misr_sel;   // 0: golden of granted core, 1: misr_fixed
  logic [SW-1:0] misr_fixed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- engine model ----------------
  task automatic eng_clear();
    eng_init = 1'b0; eng_running = 1'b0; eng_finish = 1'b0; misr_sig = '0;
  endtask

  task automatic run_engine();
    int c;
    logic [SW-1:0] sig;
    c = 0;
    for (int k = 0; k < N; k++) if (grant[k]) c = k;
    sig = (misr_sel != 0) ? misr_fixed : exp_arr[c];
    if (eng_mode == 1) return;
    if (eng_mode == 2) begin
      eng_running = 1'b1; eng_finish = 1'b1; misr_sig = sig;
      repeat (2) @(negedge clk);
      eng_clear();
      return;
    end
    eng_init = 1'b1;
    @(negedge clk);
    eng_init = 1'b0;
    if (reset) begin eng_clear(); return; end
    eng_running = 1'b1;
    for (int k = 0; k < run_len; k++) begin
      @(negedge clk);
      if (reset) begin eng_clear(); return; end
    end
    eng_finish = 1'b1; misr_sig = sig;
    @(negedge clk);
    eng_clear();
  endtask

  initial begin
    eng_clear();
    forever begin
      @(negedge clk);
      if (!reset && eng_start) run_engine();
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  int          cyc = 0;
  logic [N-1:0] grant_q = '0;
  logic [N-1:0] req_q = '0;
  logic [CW-1:0] pat_q = '0;
  int          last_core = N - 1;
  int          start_cyc = 0;
  int          idle_gap = 0;
  int          min_gap = 1000;
  bit          seen_session = 0;
  int          start_cnt = 0;
  logic [N-1:0] m_pass = '0, m_fail = '0;
  logic        m_tmo = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    bit rise, fell;
    int ec;
    logic [SW-1:0] sig;
    cyc++;
    if (reset) begin
      m_pass = '0; m_fail = '0; m_tmo = 1'b0;
      last_core = N - 1; grant_q = '0; seen_session = 0; idle_gap = 0;
    end else begin
      if (eng_start) start_cnt++;
      rise = (grant != 0) && (grant_q == 0);
      fell = (grant == 0) && (grant_q != 0);
      check("eng_start_pulse", eng_start, rise);
      if (rise) begin
        ec = rr_pick(req_q, last_core);
        check("grant_order", grant, (ec < 0) ? 0 : (1 << ec));
        check("eng_nclock_latch", eng_nclock, (pat_q == 0) ? 1 : pat_q);
        if (seen_session) begin
          check("sched_gap", idle_gap >= 3, 1);
          if (idle_gap < min_gap) min_gap = idle_gap;
        end
        last_core = ec; start_cyc = cyc; seen_session = 1;
      end
      if (grant == 0) idle_gap++; else idle_gap = 0;
      check("done_pulse", done, fell ? (1 << last_core) : 0);
      if (fell) begin
        if (eng_mode == 1) begin
          check("tmo_latency", cyc - start_cyc, TMO_T + 1);
          m_pass[last_core] = 1'b0; m_fail[last_core] = 1'b1; m_tmo = 1'b1;
        end else begin
          sig = (misr_sel != 0) ? misr_fixed : exp_arr[last_core];
          m_pass[last_core] = (sig == exp_arr[last_core]);
          m_fail[last_core] = (sig != exp_arr[last_core]);
        end
      end
      check("pass_bits", pass, m_pass);
      check("fail_bits", fail, m_fail);
      check("tmo_err", tmo_err, m_tmo);
      if (grant != 0) check("busy_in_session", busy, 1);
      grant_q = grant; req_q = req; pat_q = pat_count;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_grant(input int max);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk); #1;
      if (grant != 0) ok = 1;
    end
    check("wait_grant", ok, 1);
  endtask

  task automatic wait_done(input int max);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk); #1;
      if (done != 0) ok = 1;
    end
    check("wait_done", ok, 1);
  endtask

  task automatic wait_idle(input int max);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy && grant == 0) ok = 1;
    end
    check("wait_idle", ok, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [N-1:0] seq [$];
    logic [N-1:0] gprev;
    logic [N-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int s0;

    reset = 1'b1; req = '0; pat_count = '0;
    eng_mode = 0; run_len = 2; misr_sel = 0; misr_fixed = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_nclock", eng_nclock, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass_fail", {pass, fail, tmo_err}, 0);
    reset = 1'b0;

    // Contention: all cores held, round robin from core 0
    req = 4'b1111; pat_count = 8'd3; run_len = 2; misr_sel = 0; min_gap = 1000;
    gprev = '0;
    for (int i = 0; i < 300 && seq.size() < 5; i++) begin
      @(posedge clk); #1;
      if (grant != 0 && gprev == 0) seq.push_back(grant);
      gprev = grant;
    end
    req = '0;
    check("contention_count", seq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seq.size()) check("contention_seq", seq[i], exp_seq[i]);
    check("contention_min_gap", min_gap, 3);
    wait_idle(50);

    // Single core, matching signature
    s0 = start_cnt;
    req = 4'b0001; pat_count = 8'd5; run_len = 3; misr_sel = 0;
    wait_grant(20);
    req = '0;
    wait_done(60);
    check("single_done", done, 4'b0001);
    check("single_pass0", pass[0], 1);
    check("single_nclock", eng_nclock, 5);
    check("single_start_once", start_cnt - s0, 1);
    wait_idle(20);

    // Mismatching signature on core 1
    req = 4'b0010; pat_count = 8'd4; misr_sel = 1; misr_fixed = 16'hBEEF;
    wait_grant(20);
    req = '0;
    wait_done(60);
    check("mismatch_fail1", fail[1], 1);
    check("mismatch_pass1", pass[1], 0);
    check("mismatch_keeps_pass0", pass[0], 1);
    wait_idle(20);

    // Timeout: engine never runs
    eng_mode = 1; misr_sel = 0; req = 4'b0100;
    wait_grant(20);
    req = '0;
    wait_done(60);
    check("tmo_flag", tmo_err, 1);
    check("tmo_fail2", fail[2], 1);
    wait_idle(20);
    check("tmo_back_idle", busy, 0);

    // Running+finish in one cycle, pat_count=0 treated as 1
    eng_mode = 2; req = 4'b1000; pat_count = 8'd0;
    wait_grant(20);
    req = '0;
    check("pat0_nclock", eng_nclock, 1);
    wait_done(40);
    check("fastpath_pass3", pass[3], 1);
    wait_idle(20);

    // Reset during RUN abandons the session; pointer returns to core 0
    eng_mode = 0; run_len = 10; pat_count = 8'd7; req = 4'b0001;
    wait_grant(20);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_eng", {eng_start, eng_nclock}, 0);
    check("midrst_flags", {done, pass, fail, tmo_err}, 0);
    @(posedge clk); #1;
    reset = 1'b0; req = 4'b0011; run_len = 2;
    @(posedge clk); #1;
    check("post_rst_no_start", eng_start, 0);
    wait_grant(20);
    check("post_rst_grant", grant, 4'b0001);
    req = '0;
    wait_done(60);
    check("post_rst_pass0", pass[0], 1);
    wait_idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/bist_scheduler.md
BIST_SCHEDULER -- requirements
Module: bist_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of cores requesting BIST.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the pattern and clock counts.
REQ-003 The block SHALL have parameter SIG_W, default 16, width of the MISR signature.
REQ-004 The block SHALL have parameter TMO, default 255, watchdog limit in cycles per session.
REQ-005 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1; reset is asynchronous and active-high; clock is clk.
REQ-007 The block SHALL have port req, input, N_REQ, level BIST request per core.
REQ-008 The block SHALL have port pat_count, input, CNT_W, patterns per session; a value of 0 is treated as 1.
REQ-009 The block SHALL have port exp_sig, input, N_REQ*SIG_W, golden signature per core, with slice i for core i.
REQ-010 The block SHALL have port eng_start, output, 1, single-cycle start pulse to the shared BIST engine.
REQ-011 The block SHALL have port eng_nclock, output, CNT_W, pattern count latched for the engine.
REQ-012 The block SHALL have ports eng_init, eng_running and eng_finish, input, 1 each, engine phase indicators.
REQ-013 The block SHALL have port misr_sig, input, SIG_W, engine signature, valid while eng_finish=1.
REQ-014 The block SHALL have port grant, output, N_REQ, one-hot owner of the engine, or zero when idle.
REQ-015 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 The block SHALL have ports done, pass and fail, output, N_REQ each: done is a one-cycle pulse per core; pass and fail are sticky per core.
REQ-017 The block SHALL have port tmo_err, output, 1, sticky watchdog flag.

Function
REQ-018 FSM states SHALL be IDLE, ARB, LAUNCH, WAIT_RUN, RUN, CHECK and RELEASE.
REQ-019 IDLE SHALL go to ARB on the next edge when any req bit is 1.
REQ-020 ARB SHALL pick the first requesting core after the last granted core, in round-robin order; after reset the search starts at core 0.
REQ-021 ARB SHALL register grant and latch eng_nclock = max(pat_count, 1), then go to LAUNCH.
REQ-022 LAUNCH SHALL assert eng_start for exactly one cycle, then go to WAIT_RUN.
REQ-023 WAIT_RUN SHALL go to RUN when eng_running=1; eng_init SHALL be tolerated but SHALL NOT be required.
REQ-024 RUN SHALL go to CHECK when eng_finish=1.
REQ-025 CHECK SHALL compare misr_sig with the exp_sig slice of the granted core, in one cycle.
- On a match, the core's pass bit SHALL be set and its fail bit cleared.
- On a mismatch, the core's fail bit SHALL be set and its pass bit cleared.
- The core's done bit SHALL pulse.
REQ-026 From CHECK the FSM SHALL go to RELEASE, which SHALL clear grant and return to IDLE.
REQ-027 The minimum scheduling gap between two sessions SHALL be 3 cycles (RELEASE, IDLE, ARB).
REQ-028 A watchdog counter SHALL clear in LAUNCH and increment in WAIT_RUN and RUN.
REQ-029 When the watchdog reaches TMO, the FSM SHALL set tmo_err and the granted core's fail bit, pulse done, and go to RELEASE.
REQ-030 A req deasserted after grant SHALL NOT abort the session.
REQ-031 A core with req still high after its session SHALL be rescheduled only after all other pending cores.
REQ-032 If eng_running and eng_finish are high in the same WAIT_RUN cycle, the FSM SHALL go directly to CHECK.
REQ-033 pat_count changes after ARB SHALL NOT affect the session in progress.
REQ-034 A new session for a core SHALL overwrite that core's pass and fail bits only in CHECK or on timeout.

Reset
REQ-035 Asserting reset SHALL asynchronously force:
- state=IDLE
- grant=0, eng_start=0, eng_nclock=0, busy=0
- done=0, pass=0, fail=0, tmo_err=0
- watchdog=0, round-robin pointer=core N_REQ-1
REQ-036 Reset asserted mid-session SHALL abandon the session with no done pulse; eng_start SHALL be low in the first cycle after reset release.

Structure
REQ-037 A shared package SHALL hold the state enumeration and the default widths (CNT_W, SIG_W).
REQ-038 The round-robin selector SHALL be a sub-module, rr_arbiter, combinational with a registered pointer.

Verification
REQ-039 Single core: req=0001, pat_count=5, engine returns misr_sig equal to exp_sig[0] -> eng_start pulses once, eng_nclock=5, done[0] pulses, pass[0]=1.
REQ-040 Mismatch: req=0010, misr_sig=16'hBEEF, exp_sig[1]=16'hBEE0 -> fail[1]=1, pass[1]=0.
REQ-041 Contention: req=1111 held high -> grant order 0001, 0010, 0100, 1000, 0001, with at least 3 cycles between grants.
REQ-042 Timeout with TMO=20: engine never raises eng_running -> tmo_err=1 and fail[g]=1 at 20 cycles after LAUNCH, then IDLE.
REQ-043 Reset raised during RUN -> all outputs are 0 immediately; a later req=0001 restarts from core 0.
REQ-044 pat_count=0 -> eng_nclock=1 and the session completes normally.
